// File: rtl/entrada_bcd_multicampo.sv
// Keypad data-entry block: collects NUM_CAMPOS decimal fields of NUM_DIGITOS BCD
// digits each, converts every committed field to binary and hands it off over valid/ready.
module entrada_bcd_multicampo #(
  parameter  int NUM_CAMPOS  = 7,
  parameter  int NUM_DIGITOS = 4,
  parameter  int BIN_W       = 14,
  localparam int CAMPO_W     = (NUM_CAMPOS > 1) ? $clog2(NUM_CAMPOS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [0:9]               IO,
  input  logic                     clear,
  input  logic                     prox,
  input  logic                     apaga,
  output logic [CAMPO_W-1:0]       campo,
  output logic [4*NUM_DIGITOS-1:0] digitos,
  output logic [3:0]               cont_digitos,
  output logic                     ocupado,
  output logic [BIN_W-1:0]         valor,
  output logic [CAMPO_W-1:0]       valor_campo,
  output logic                     valor_valid,
  input  logic                     valor_ready,
  output logic                     completo
);

  localparam int DW     = 4 * NUM_DIGITOS;
  localparam int CONV_W = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;

  typedef enum logic [1:0] {ENTRADA, CONVERTE, ENTREGA, COMPLETO} state_t;

  state_t              state, state_d;
  logic [0:9]          io_q;
  logic                clear_q, prox_q, apaga_q;
  logic [0:9]          rise_io;
  logic                ev_clear, ev_prox, ev_apaga, ev_digit;
  logic [3:0]          dval;
  logic [BIN_W-1:0]    acc;
  logic [DW-1:0]       conv_sr;
  logic [CONV_W-1:0]   conv_cnt;
  logic                ultimo;

  // NOTE: every register in this block uses <= so all flops see pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_q    <= '0;
      clear_q <= 1'b0;
      prox_q  <= 1'b0;
      apaga_q <= 1'b0;
    end else begin
      io_q    <= IO;
      clear_q <= clear;
      prox_q  <= prox;
      apaga_q <= apaga;
    end
  end

  assign rise_io  = IO & ~io_q;
  assign ev_clear = clear & ~clear_q;
  assign ev_prox  = prox  & ~prox_q;
  assign ev_apaga = apaga & ~apaga_q;
  // Two keys rising together is ambiguous, so it is not a digit at all.
  assign ev_digit = $onehot(rise_io);
  assign ultimo   = (campo == CAMPO_W'(NUM_CAMPOS - 1));

  // NOTE: dval gets a default before the loop so this stays combinational (no latch)
  // on cycles where no key rises.
  always_comb begin
    dval = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (rise_io[k]) dval = 4'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ENTRADA;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ENTRADA:  if (ev_prox) state_d = CONVERTE;
      CONVERTE: if (conv_cnt == CONV_W'(NUM_DIGITOS - 1)) state_d = ENTREGA;
      ENTREGA:  if (valor_ready) state_d = ultimo ? COMPLETO : ENTRADA;
      COMPLETO: if (ev_prox) state_d = ENTRADA;
      default:  state_d = ENTRADA;
    endcase
    if (ev_clear) state_d = ENTRADA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      campo        <= '0;
      digitos      <= '0;
      cont_digitos <= 4'd0;
      acc          <= '0;
      conv_sr      <= '0;
      conv_cnt     <= '0;
    end else if (ev_clear || (state == COMPLETO && ev_prox)) begin
      campo        <= '0;
      digitos      <= '0;
      cont_digitos <= 4'd0;
      acc          <= '0;
      conv_sr      <= '0;
      conv_cnt     <= '0;
    end else begin
      case (state)
        ENTRADA: begin
          if (ev_prox) begin
            // Conversion works on a private copy so the display keeps the committed digits.
            acc      <= '0;
            conv_cnt <= '0;
            conv_sr  <= digitos;
          end else if (ev_apaga) begin
            if (cont_digitos != 4'd0) begin
              digitos      <= digitos >> 4;
              cont_digitos <= cont_digitos - 4'd1;
            end
          end else if (ev_digit && cont_digitos < 4'(NUM_DIGITOS)) begin
            digitos      <= (digitos << 4) | DW'(dval);
            cont_digitos <= cont_digitos + 4'd1;
          end
        end
        CONVERTE: begin
          acc      <= acc * BIN_W'(10) + BIN_W'(conv_sr[DW-1 -: 4]);
          conv_sr  <= conv_sr << 4;
          conv_cnt <= conv_cnt + 1'b1;
        end
        ENTREGA: begin
          if (valor_ready && !ultimo) begin
            campo        <= campo + 1'b1;
            digitos      <= '0;
            cont_digitos <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ocupado     = (state == CONVERTE);
  assign valor_valid = (state == ENTREGA);
  assign completo    = (state == COMPLETO);
  assign valor       = acc;
  assign valor_campo = campo;

endmodule

// File: tb/tb_entrada_bcd_multicampo.sv
// Scoreboard bench for entrada_bcd_multicampo: directed key sequences push expected
// deliveries; a monitor pops and compares on every valor handshake.
module tb_entrada_bcd_multicampo;

  localparam int NC = 7;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [0:9]      io = '0;
  logic            clear = 1'b0, prox = 1'b0, apaga = 1'b0;
  logic [CW-1:0]   campo, valor_campo;
  logic [4*ND-1:0] digitos;
  logic [3:0]      cont_digitos;
  logic            ocupado, valor_valid, completo;
  logic [BW-1:0]   valor;
  logic            valor_ready = 1'b0;

  typedef struct { int v; int c; } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  entrada_bcd_multicampo #(.NUM_CAMPOS(NC), .NUM_DIGITOS(ND), .BIN_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .IO(io), .clear(clear), .prox(prox), .apaga(apaga),
    .campo(campo), .digitos(digitos), .cont_digitos(cont_digitos), .ocupado(ocupado),
    .valor(valor), .valor_campo(valor_campo), .valor_valid(valor_valid),
    .valor_ready(valor_ready), .completo(completo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted delivery must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && valor_valid && valor_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_delivery", 32'(valor), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valor", 32'(valor), 32'(e.v));
        check("valor_campo", 32'(valor_campo), 32'(e.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    io[k] = 1'b1;
    tick();
    io = '0;
    tick();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!valor_valid && n < 20) begin
      tick();
      n++;
    end
    if (!valor_valid) check("valid_timeout", 32'(valor_valid), 32'd1);
  endtask

  // Commit with valor_ready high; returns one cycle after the handshake.
  task automatic commit();
    prox = 1'b1;
    tick();
    prox = 1'b0;
    wait_valid();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_campo"}, 32'(campo), 0);
    check({tag, "_digitos"}, 32'(digitos), 0);
    check({tag, "_cont"}, 32'(cont_digitos), 0);
    check({tag, "_ocupado"}, 32'(ocupado), 0);
    check({tag, "_valor"}, 32'(valor), 0);
    check({tag, "_valor_campo"}, 32'(valor_campo), 0);
    check({tag, "_valid"}, 32'(valor_valid), 0);
    check({tag, "_completo"}, 32'(completo), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Field 0: 1,2,3 -> 123
    press(1); press(2); press(3);
    check("f0_digitos", 32'(digitos), 32'h0123);
    check("f0_cont", 32'(cont_digitos), 3);
    valor_ready = 1'b1;
    sb.push_back('{123, 0});
    prox = 1'b1;
    for (int i = 0; i < ND; i++) begin
      tick();
      prox = 1'b0;
      check("f0_ocupado", 32'(ocupado), 1);
      check("f0_not_valid", 32'(valor_valid), 0);
    end
    tick();
    check("f0_valid", 32'(valor_valid), 1);
    check("f0_ocupado_end", 32'(ocupado), 0);
    tick();
    check("f0_valid_drop", 32'(valor_valid), 0);
    check("f0_next_campo", 32'(campo), 1);
    check("f0_next_digitos", 32'(digitos), 0);

    // Field 1: 9,9,9,9,5 (fifth ignored), apaga, 7 -> 9997
    press(9); press(9); press(9); press(9); press(5);
    check("f1_full", 32'(digitos), 32'h9999);
    check("f1_full_cont", 32'(cont_digitos), 4);
    apaga = 1'b1; tick(); apaga = 1'b0; tick();
    check("f1_apaga", 32'(digitos), 32'h0999);
    check("f1_apaga_cont", 32'(cont_digitos), 3);
    press(7);
    check("f1_seven", 32'(digitos), 32'h9997);
    sb.push_back('{9997, 1});
    commit();
    check("f1_next_campo", 32'(campo), 2);

    // Field 2: backpressure on 42
    press(4); press(2);
    valor_ready = 1'b0;
    sb.push_back('{42, 2});
    prox = 1'b1; tick(); prox = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      io = (i == 1) ? 10'b0000010000 : '0;
      prox = (i == 3);
      tick();
      check("bp_valid", 32'(valor_valid), 1);
      check("bp_valor", 32'(valor), 42);
      check("bp_valor_campo", 32'(valor_campo), 2);
    end
    io = '0; prox = 1'b0;
    check("bp_digitos", 32'(digitos), 32'h0042);
    valor_ready = 1'b1;
    tick();
    tick();
    check("bp_valid_drop", 32'(valor_valid), 0);
    check("bp_next_campo", 32'(campo), 3);

    // Field 3: keys 3+5 together ignored; prox+apaga only prox acts
    io[3] = 1'b1; io[5] = 1'b1; tick(); io = '0; tick();
    check("dual_key_digitos", 32'(digitos), 0);
    check("dual_key_cont", 32'(cont_digitos), 0);
    press(8);
    sb.push_back('{8, 3});
    prox = 1'b1; apaga = 1'b1; tick(); prox = 1'b0; apaga = 1'b0;
    check("prox_apaga_ocupado", 32'(ocupado), 1);
    check("prox_apaga_digitos", 32'(digitos), 32'h0008);
    check("prox_apaga_cont", 32'(cont_digitos), 1);
    wait_valid();
    tick();
    check("f3_next_campo", 32'(campo), 4);

    // Field 4: clear while valor_valid is pending
    press(6);
    valor_ready = 1'b0;
    prox = 1'b1; tick(); prox = 1'b0;
    wait_valid();
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_valid", 32'(valor_valid), 0);
    check("clr_campo", 32'(campo), 0);
    check("clr_digitos", 32'(digitos), 0);
    check("clr_cont", 32'(cont_digitos), 0);
    tick();
    valor_ready = 1'b1;

    // Full record: fields 0..6 carry values 0..6, each key held several cycles
    for (int f = 0; f < NC; f++) begin
      io[f] = 1'b1; tick(); tick(); tick(); io = '0; tick();
      check("rec_digitos", 32'(digitos), 32'(f));
      check("rec_cont", 32'(cont_digitos), 1);
      sb.push_back('{f, f});
      commit();
      if (f < NC - 1) begin
        check("rec_campo", 32'(campo), 32'(f + 1));
        check("rec_completo_lo", 32'(completo), 0);
      end else begin
        check("rec_completo_hi", 32'(completo), 1);
      end
    end
    press(2);
    check("cpl_digit_ignored", 32'(digitos), 32'h0006);
    check("cpl_still", 32'(completo), 1);
    prox = 1'b1; tick(); prox = 1'b0; tick();
    check("cpl_restart_campo", 32'(campo), 0);
    check("cpl_restart_completo", 32'(completo), 0);
    check("cpl_restart_digitos", 32'(digitos), 0);

    // Reset during conversion, then an empty field converts to 0
    press(5);
    prox = 1'b1; tick(); prox = 1'b0; tick();
    check("rst_mid_ocupado", 32'(ocupado), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    sb.push_back('{0, 0});
    commit();
    check("empty_next_campo", 32'(campo), 1);

    tick();
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
